imem_program_loader: RTL and testbench

//   Writer side of the instruction memory: receives a boot image as a byte stream,

---
 rtl/imem_program_loader_pkg.sv | 18 +
 rtl/imem_program_loader_word.sv | 34 +++
 rtl/imem_program_loader.sv | 167 ++++++++++++++++
 tb/tb_imem_program_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_program_loader_pkg.sv
// Shared definitions for the boot-image loader, instruction memory and CPU top.
// Optional feature macro used by the loader: LOADER_CHECKSUM_EN.
package imem_program_loader_pkg;

    // Default instruction memory depth is 2**IMEM_ADDR_W words.
    localparam int IMEM_ADDR_W = 10;

    // Loader FSM states. CHK is only reachable when LOADER_CHECKSUM_EN is defined.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CHK  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } loader_state_t;

endpackage

// File: rtl/imem_program_loader_word.sv
// le_word_assembler: collects four stream bytes into one little-endian 32-bit word.
// The first byte received ends up in bits [7:0]. word_valid is high in the same
// cycle as the 4th byte, and word_data then holds the completed word.
module le_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [1:0]  byte_cnt;
    logic [23:0] shreg;

    assign word_valid = byte_valid && (byte_cnt == 2'd3);
    assign word_data  = {byte_data, shreg};

    // Count bytes within the word and shift each new byte in from the top.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt <= 2'd0;
            shreg    <= 24'd0;
        end else if (clear) begin
            byte_cnt <= 2'd0;
            shreg    <= 24'd0;
        end else if (byte_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            shreg    <= {byte_data, shreg[23:8]};
        end
    end

endmodule

// File: rtl/imem_program_loader.sv
// imem_program_loader: receives a boot image as a byte stream (4-byte LE word
// count followed by the words) and writes it into instruction memory, holding
// the CPU in reset until the image is complete.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR checksum
// byte covering all data bytes; without it the last data word finishes the load.
module imem_program_loader
    import imem_program_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    // Largest legal word count is the full memory; the index is one bit wider so
    // that a completely full image can be counted without wrapping.
    localparam logic [31:0]   MAX_WORDS = 32'd1 << ADDR_W;
    localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

    loader_state_t   state;
    loader_state_t   state_next;

    logic            byte_fire;
    logic            start_ok;
    logic            asm_byte_valid;
    logic            word_valid;
    logic [31:0]     word_data;
    logic [ADDR_W:0] word_idx;
    logic [ADDR_W:0] len_q;
    logic            last_word;

    assign byte_fire      = s_valid && s_ready;
    assign start_ok       = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
    assign asm_byte_valid = byte_fire && ((state == ST_LEN) || (state == ST_DATA));
    assign last_word      = (word_idx + IDX_ONE) == len_q;

    le_word_assembler u_word (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_ok),
        .byte_valid (asm_byte_valid),
        .byte_data  (s_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] chk_q;
    logic       chk_fire;

    assign chk_fire = byte_fire && (state == ST_CHK);

    // Running XOR over the data bytes only; the length header is excluded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_q <= 8'd0;
        end else if (start_ok) begin
            chk_q <= 8'd0;
        end else if (asm_byte_valid && (state == ST_DATA)) begin
            chk_q <= chk_q ^ s_data;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; phase changes happen on the edge that takes the 4th byte.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_next = ST_LEN;
                end
            end
            ST_LEN: begin
                if (word_valid) begin
                    if (word_data == 32'd0) begin
                        state_next = ST_DONE;
                    end else if (word_data > MAX_WORDS) begin
                        state_next = ST_ERR;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (word_valid && last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    state_next = ST_CHK;
`else
                    state_next = ST_DONE;
`endif
                end
            end
            ST_CHK: begin
`ifdef LOADER_CHECKSUM_EN
                if (chk_fire) begin
                    state_next = (s_data == chk_q) ? ST_DONE : ST_ERR;
                end
`else
                state_next = ST_ERR;
`endif
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        s_ready  = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        cpu_hold = 1'b1;
        case (state)
            ST_LEN, ST_DATA, ST_CHK: s_ready = 1'b1;
            ST_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            ST_ERR:  error = 1'b1;
            default: ;
        endcase
    end

    // Length capture, word index and the registered one-cycle memory write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= 32'd0;
            word_idx   <= '0;
            len_q      <= '0;
        end else begin
            imem_we <= 1'b0;
            if (start_ok) begin
                word_idx <= '0;
                len_q    <= '0;
            end else if ((state == ST_LEN) && word_valid) begin
                len_q <= word_data[ADDR_W:0];
            end else if ((state == ST_DATA) && word_valid) begin
                imem_we    <= 1'b1;
                imem_waddr <= word_idx[ADDR_W-1:0];
                imem_wdata <= word_data;
                word_idx   <= word_idx + IDX_ONE;
            end
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader. Expected memory writes are queued
// as each word is driven and compared when imem_we pulses.
// Honours LOADER_CHECKSUM_EN the same way the design does.
module tb_imem_program_loader;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W+31:0] expq[$];
    logic [ADDR_W+31:0] sb_entry;
    logic [31:0]        img[0:7];

    imem_program_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (imem_we !== 1'b0) begin
            if (expq.size() == 0) begin
                checkOutput("unexpected_write", 32'(imem_waddr), 32'hFFFF_FFFF);
            end else begin
                sb_entry = expq.pop_front();
                checkOutput("waddr", 32'(imem_waddr), 32'(sb_entry[ADDR_W+31:32]));
                checkOutput("wdata", imem_wdata, sb_entry[31:0]);
            end
        end
    end

    // Offer one byte until accepted (bounded), then idle for gap cycles.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int n;
        s_data  = b;
        s_valid = 1'b1;
        n = 0;
        while (s_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (s_ready !== 1'b1) begin
            checkOutput("ready_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic sendWord(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(w[8*k +: 8], gap);
        end
    endtask

    task automatic pushWord(input int addr, input logic [31:0] data);
        expq.push_back({ADDR_W'(addr), data});
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic checkFlags(input string t, input logic d, input logic e, input logic h, input logic r);
        checkOutput({t, "_done"}, 32'(done), 32'(d));
        checkOutput({t, "_error"}, 32'(error), 32'(e));
        checkOutput({t, "_cpu_hold"}, 32'(cpu_hold), 32'(h));
        checkOutput({t, "_s_ready"}, 32'(s_ready), 32'(r));
    endtask

    task automatic checkResetValues(input string t);
        checkFlags(t, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput({t, "_imem_we"}, 32'(imem_we), 32'd0);
        checkOutput({t, "_imem_waddr"}, 32'(imem_waddr), 32'd0);
        checkOutput({t, "_imem_wdata"}, imem_wdata, 32'd0);
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Full load of img[0..nw-1]; chk_flip corrupts the trailing checksum byte.
    task automatic loadImage(input int nw, input int gap, input logic [7:0] chk_flip);
        logic [7:0] x;
        x = chk_flip;
        pulseStart();
        checkFlags("loading", 1'b0, 1'b0, 1'b1, 1'b1);
        sendWord(32'(nw), gap);
        for (int i = 0; i < nw; i++) begin
            pushWord(i, img[i]);
            x = x ^ img[i][7:0] ^ img[i][15:8] ^ img[i][23:16] ^ img[i][31:24];
            sendWord(img[i], gap);
        end
`ifdef LOADER_CHECKSUM_EN
        if (nw > 0) begin
            applyStimulus(x, gap);
        end
`endif
        settle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        s_data  = 8'd0;
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Two-word image from the reference example.
        img[0] = 32'h0000_0013;
        img[1] = 32'h0010_0093;
        loadImage(2, 0, 8'h00);
        checkFlags("two_words", 1'b1, 1'b0, 1'b0, 1'b0);

        // Bytes offered while not ready must not be consumed or written.
        s_data  = 8'hAA;
        s_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        s_valid = 1'b0;
        checkFlags("idle_bytes", 1'b1, 1'b0, 1'b0, 1'b0);

        // Zero-length image finishes straight from the header.
        loadImage(0, 0, 8'h00);
        checkFlags("zero_len", 1'b1, 1'b0, 1'b0, 1'b0);

        // One word more than capacity is rejected.
        pulseStart();
        sendWord(32'h0000_0401, 0);
        checkFlags("overflow", 1'b0, 1'b1, 1'b1, 1'b0);
        settle();
        checkOutput("overflow_no_writes", 32'(expq.size()), 32'd0);

        // Gapped stream, one byte every third cycle.
        img[0] = 32'hDEAD_BEEF;
        img[1] = 32'h1234_5678;
        img[2] = 32'h8000_0001;
        loadImage(3, 2, 8'h00);
        checkFlags("gapped", 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        img[0] = 32'h0000_0013;
        loadImage(1, 0, 8'h00);
        checkFlags("chk_good", 1'b1, 1'b0, 1'b0, 1'b0);
        loadImage(1, 0, 8'h01);
        checkFlags("chk_bad", 1'b0, 1'b1, 1'b1, 1'b0);
`endif

        // Reset after two of three words discards all loader state.
        img[0] = 32'hA5A5_0001;
        img[1] = 32'h5A5A_0002;
        img[2] = 32'hC3C3_0003;
        pulseStart();
        sendWord(32'd3, 0);
        pushWord(0, img[0]);
        sendWord(img[0], 0);
        pushWord(1, img[1]);
        sendWord(img[1], 0);
        settle();
        reset = 1'b1;
        @(posedge clk); #1;
        checkResetValues("mid_reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Reload from address 0 with a start pulse ignored mid-DATA.
        pulseStart();
        sendWord(32'd3, 1);
        pushWord(0, img[0]);
        sendWord(img[0], 1);
        pulseStart();
        checkFlags("start_ignored", 1'b0, 1'b0, 1'b1, 1'b1);
        pushWord(1, img[1]);
        sendWord(img[1], 0);
        pushWord(2, img[2]);
        sendWord(img[2], 0);
`ifdef LOADER_CHECKSUM_EN
        applyStimulus(img[0][7:0] ^ img[0][15:8] ^ img[0][23:16] ^ img[0][31:24] ^
                      img[1][7:0] ^ img[1][15:8] ^ img[1][23:16] ^ img[1][31:24] ^
                      img[2][7:0] ^ img[2][15:8] ^ img[2][23:16] ^ img[2][31:24], 0);
`endif
        settle();
        checkFlags("reload", 1'b1, 1'b0, 1'b0, 1'b0);

        checkOutput("sb_empty", 32'(expq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
